serial_subtractor: RTL
======================

// Module: serial_subtractor
//
// PURPOSE
// Bit-serial N-bit subtractor computing d = a - b, the inverse operation of our full adders.
// It processes one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
// It is used where area matters more than latency, and as a sequential datapath building block.
// A start/busy/done handshake makes it drop-in for small control FSMs.
//
// PARAMETERS
// WIDTH  8  operand and result width in bits; legal range 1..32
//
// PORTS
// clk    in   1      rising-edge clock
// rst    in   1      asynchronous, active-high reset
// start  in   1      request a new subtraction; sampled when the block is not busy
// a      in   WIDTH  minuend; captured on the accepted start edge
// b      in   WIDTH  subtrahend; captured on the accepted start edge
// busy   out  1      high while in RUN
// done   out  1      single-cycle pulse: d and bout are valid
// d      out  WIDTH  difference (a - b) mod 2^WIDTH; held until the next accepted start
// bout   out  1      final borrow: 1 when a < b (unsigned); held with d
// ovf    out  1      signed overflow; present only when SERIAL_SUB_OVF_EN is defined
//
// BEHAVIOUR
// - Reset: asynchronous, active-high. While rst=1:
//   - state=IDLE; busy=0, done=0, d=0, bout=0, ovf=0.
//   - Internal shift registers, bit counter and borrow flip-flop are cleared.
//   - Asserting rst mid-RUN aborts the operation; no done is produced.
// - FSM states and transitions:
//   - IDLE: start=1 -> capture a and b, clear borrow and counter, go to RUN.
//   - RUN: one bit per cycle, LSB first, using the current a/b LSBs and the borrow register br:
//       diff = a0 ^ b0 ^ br
//       br'  = (~a0 & b0) | (~(a0 ^ b0) & br)
//   - RUN: diff shifts into the result register at the MSB end; operand registers shift right.
//   - RUN: counter counts 0..WIDTH-1. On the edge that processes bit WIDTH-1:
//       d <= final result; bout <= br'; go to DONE.
//   - DONE: done=1 for exactly one cycle, then IDLE.
//   - DONE: start=1 in DONE is accepted exactly as in IDLE, allowing back-to-back operations.
// - Latency: start accepted at edge E; busy=1 during cycles E+1..E+WIDTH; done=1 in the cycle after edge E+WIDTH.
// - Throughput: one result per WIDTH+1 cycles back-to-back.
// - start while busy=1 is ignored; a and b may change freely during RUN without affecting the result.
// - d and bout change only on the completion edge. Intermediate values never appear on d.
// - WIDTH=1: RUN lasts one cycle. The counter must not wrap or underflow.
// - Arithmetic: unsigned modulo 2^WIDTH. bout is equivalent to the carry-out of a + ~b + 1, inverted.
//
// CONFIGURATION
// - SERIAL_SUB_OVF_EN defined:
//   - Adds output ovf = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]), using the captured operands.
//   - ovf is registered on the completion edge alongside d, held with d, and reset to 0.
// - SERIAL_SUB_OVF_EN undefined:
//   - The ovf port and its logic do not exist; all other behaviour is identical.
//
// TESTING
// (WIDTH=8 unless stated; check d/bout in the done cycle.)
// 1. a=0x35, b=0x12, start 1 cycle -> done 8 cycles after the start edge; d=0x23, bout=0; busy high for exactly 8 cycles.
// 2. a=0x12, b=0x35 -> d=0xDD, bout=1. Then a=0x00, b=0x01 -> d=0xFF, bout=1. Then a=0xFF, b=0xFF -> d=0x00, bout=0.
// 3. Hold start=1 continuously with new operands each done cycle -> results every 9 cycles; each matches a-b.
//    Pulse start mid-RUN -> ignored; change a/b mid-RUN -> result unaffected.
// 4. Assert rst at RUN bit 3 -> busy, done, d and bout go to 0 immediately (asynchronously); no done follows.
//    The next start gives a correct result.
// 5. With SERIAL_SUB_OVF_EN: 0x80-0x01 -> d=0x7F, ovf=1; 0x7F-0xFF -> d=0x80, ovf=1; 0x05-0x03 -> ovf=0.
//    Without the macro: the build succeeds with no ovf port.
// 6. WIDTH=1 build: exhaustively test all 4 a/b pairs -> done 1 cycle after start; d=a^b; bout=~a&b.
//    Random regression of 1000 operand pairs at WIDTH=8 and WIDTH=32 against a reference model.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor d = a - b, LSB first, one full-subtractor cell plus a borrow flop.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;

    logic             diff;
    logic             br_nxt;
    logic [WIDTH-1:0] res_shift;

    assign diff   = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    // New difference bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = diff;
        end else begin : g_res_wn
            assign res_shift = {diff, res_q[WIDTH-1:1]};
        end
    endgenerate

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                br_d  = br_nxt;
                // Counter holds at LAST on completion so it never wraps, even for WIDTH=1.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    d_d     = res_shift;
                    bout_d  = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign d    = d_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
